// File: rtl/cpu_pkg.sv
// Constants and types shared by the fetch front end, decoder and immediate extender.
package cpu_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Major opcode field [6:0]
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: imem request/response, EX redirect and the decode handoff.
interface inst_fetch_queue_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fifo.sv
// Small synchronous FIFO with flush; a pop and a push in the same cycle are both
// honoured even when full, since the freed slot is the one being written.
module inst_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC ownership, credit-limited imem requests, response
// queue toward decode, and redirect handling that discards wrong-path responses.
module inst_fetch_queue
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_queue_if.master bus
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]  fetch_pc;
    logic [31:0]  rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_fire;
    logic          enq;
    logic          deq;
    fetch_entry_t  enq_entry;
    fetch_entry_t  head;

    // Every issued fetch holds a queue slot until it is popped or discarded,
    // so the queue can never overflow.
    assign credit_used        = {1'b0, outstanding} + {1'b0, q_count};
    assign bus.imem_req_valid = rst_n && !bus.redirect_valid
                                && (credit_used < (CW+1)'(QDEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = bus.imem_rsp_valid && (outstanding != '0);
    assign enq      = rsp_fire && (drop_cnt == '0) && !bus.redirect_valid;
    assign deq      = bus.id_valid && bus.id_ready;

    assign enq_entry = '{pc: rsp_pc, inst: bus.imem_rsp_data};

    inst_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (bus.redirect_valid),
        .wr_en   (enq),
        .wr_data (enq_entry),
        .rd_en   (deq),
        .rd_data (head),
        .count   (q_count),
        .empty   (q_empty)
    );

    assign bus.id_valid = !q_empty;
    assign bus.id_inst  = q_empty ? NOP_INST : head.inst;
    assign bus.id_pc    = q_empty ? 32'h0    : head.pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.redirect_valid) begin
            // Everything still in flight after this cycle is wrong-path.
            fetch_pc    <= word_align(bus.redirect_pc);
            rsp_pc      <= word_align(bus.redirect_pc);
            outstanding <= outstanding - CW'(rsp_fire);
            drop_cnt    <= outstanding - CW'(rsp_fire);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (enq)      rsp_pc   <= rsp_pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench: QDEPTH=2 instance for the back-pressure/redirect/reset scenarios,
// QDEPTH=4 instance for full-rate streaming.
module tb_inst_fetch_queue;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_queue_if bus ();
    inst_fetch_queue_if bus4 ();

    inst_fetch_queue #(.RESET_PC(32'h0), .QDEPTH(2)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );
    inst_fetch_queue #(.RESET_PC(32'h0), .QDEPTH(4)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4)
    );

    int total = 0;
    int bad   = 0;
    int fires = 0;
    logic mem_hold = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] pend4[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory models: in-order, one-cycle latency; mem_hold stalls the QDEPTH=2 side.
    always @(posedge clk) begin
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back(bus.imem_req_addr);
            fires <= fires + 1;
        end
        if (!mem_hold && pend.size() > 0) begin
            bus.imem_rsp_valid <= 1'b1;
            bus.imem_rsp_data  <= word_of(pend.pop_front());
        end else begin
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= 32'h0;
        end
    end

    always @(posedge clk) begin
        if (bus4.imem_req_valid && bus4.imem_req_ready) pend4.push_back(bus4.imem_req_addr);
        if (pend4.size() > 0) begin
            bus4.imem_rsp_valid <= 1'b1;
            bus4.imem_rsp_data  <= word_of(pend4.pop_front());
        end else begin
            bus4.imem_rsp_valid <= 1'b0;
            bus4.imem_rsp_data  <= 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        int   snap;
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.id_ready        = 1'b0;
        bus4.imem_req_ready = 1'b0;
        bus4.redirect_valid = 1'b0;
        bus4.redirect_pc    = 32'h0;
        bus4.id_ready       = 1'b0;
        repeat (3) step();

        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_id_valid",  32'(bus.id_valid), 32'd0);
        check("rst_id_inst",   bus.id_inst, NOP_INST);
        check("rst_id_pc",     bus.id_pc, 32'h0);

        // Streaming on QDEPTH=4; QDEPTH=2 fills with decode stalled.
        bus.imem_req_ready  = 1'b1;
        bus4.imem_req_ready = 1'b1;
        bus4.id_ready       = 1'b1;
        snap  = fires;
        rst_n = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            check("stream_req_valid", 32'(bus4.imem_req_valid), 32'd1);
            check("stream_req_addr",  bus4.imem_req_addr, 32'(4 * (k + 1)));
            check("stream_id_pc",     bus4.id_pc, 32'(4 * (k - 1)));
            check("stream_id_inst",   bus4.id_inst, word_of(32'(4 * (k - 1))));
        end

        repeat (3) step();
        check("stall_fires",     32'(fires - snap), 32'd2);
        check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("stall_id_pc",     bus.id_pc, 32'h0);
        bus.id_ready = 1'b1;
        #1;
        check("pop0_id_pc", bus.id_pc, 32'h0);
        step();
        bus.id_ready = 1'b0;
        #1;
        check("pop1_id_pc",     bus.id_pc, 32'h4);
        check("resume_valid",   32'(bus.imem_req_valid), 32'd1);
        check("resume_addr",    bus.imem_req_addr, 32'h8);

        // Redirect with two fetches (8, 12) in flight.
        mem_hold     = 1'b1;
        bus.id_ready = 1'b1;
        step();
        step();
        bus.id_ready = 1'b0;
        #1;
        check("inflight_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        step();
        bus.redirect_valid = 1'b0;
        mem_hold           = 1'b0;
        #1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !bus.imem_req_valid; i++) begin
            seen |= bus.id_valid;
            step();
        end
        check("drop_no_id_valid", 32'(seen), 32'd0);
        check("redir_req_valid",  32'(bus.imem_req_valid), 32'd1);
        check("redir_req_addr",   bus.imem_req_addr, 32'h100);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 10 && !bus.id_valid; i++) step();
        check("redir_id_valid", 32'(bus.id_valid), 32'd1);
        check("redir_id_pc",    bus.id_pc, 32'h100);
        check("redir_id_inst",  bus.id_inst, word_of(32'h100));

        // Fill the queue, then line up redirect + response + dequeue in one cycle.
        bus.id_ready = 1'b0;
        repeat (6) step();
        check("full_id_pc",     bus.id_pc, 32'h100);
        check("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
        mem_hold     = 1'b1;
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        step();
        mem_hold = 1'b0;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        bus.id_ready       = 1'b1;
        #1;
        check("coll_id_valid",  32'(bus.id_valid), 32'd1);
        check("coll_id_pc",     bus.id_pc, 32'h104);
        check("coll_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("coll_empty",     32'(bus.id_valid), 32'd0);
        check("coll_nop",       bus.id_inst, NOP_INST);
        check("coll_pc_zero",   bus.id_pc, 32'h0);
        check("coll_next_addr", bus.imem_req_addr, 32'h200);

        // Address wrap; low redirect bits are masked.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("wrap_addr_hi", bus.imem_req_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_valid",   32'(bus.imem_req_valid), 32'd1);
        check("wrap_addr_lo", bus.imem_req_addr, 32'h0);
        step();
        check("wrap_id_pc_hi", bus.id_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_id_pc_lo", bus.id_pc, 32'h0);

        // Reset with two fetches (4, 8) in flight; stale responses must be ignored.
        mem_hold = 1'b1;
        repeat (4) step();
        check("pre_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        #1;
        check("in_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step();
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        #1;
        check("post_rst_valid", 32'(bus.imem_req_valid), 32'd1);
        check("post_rst_addr",  bus.imem_req_addr, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            step();
            seen |= bus.id_valid;
        end
        check("stale_ignored", 32'(seen), 32'd0);
        bus.imem_req_ready = 1'b1;
        step();
        step();
        check("post_rst_id_valid", 32'(bus.id_valid), 32'd1);
        check("post_rst_id_pc",    bus.id_pc, 32'h0);
        check("post_rst_id_inst",  bus.id_inst, word_of(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
